// File: rtl/systolic_drain.sv
// ============================================================================
// systolic_drain : deskews N systolic-array column streams into aligned rows
// with per-column FIFOs, a single registered ready/valid output stage and a
// frame row counter. Optional macro: SYSTOLIC_DRAIN_RELU_EN (ReLU on load).
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_drain #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10,
  parameter int N        = 4,
  parameter int DEPTH    = 4,
  parameter int ROWS     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   y_in,
  input  logic [N-1:0]         y_valid,
  output logic [N*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  // FRAC_BIT only describes the number format for the consumer.
  if (FRAC_BIT >= WIDTH || DEPTH < N) begin : g_cfg_out_of_range
  end

  logic [N-1:0]       col_empty;
  logic [N-1:0]       col_full;
  logic [N-1:0]       col_drop;
  logic [WIDTH-1:0]   col_head [N];
  logic               pop;
  logic [N*WIDTH-1:0] row_word;

  logic [N*WIDTH-1:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               overflow_q, overflow_d;
  logic [CW-1:0]      row_q, row_d;

  // A row leaves only when every column has a word and the output slot frees.
  assign pop = (&(~col_empty)) && (!out_valid_q || out_ready);

  for (genvar k = 0; k < N; k++) begin : g_col
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             push;

    assign col_empty[k] = (wr_q == rd_q);
    assign col_full[k]  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign col_head[k]  = mem_q[rd_q[AW-1:0]];

    always_comb begin
      push        = y_valid[k] && (!col_full[k] || pop);
      col_drop[k] = y_valid[k] && col_full[k] && !pop;
      wr_d        = wr_q + {{AW{1'b0}}, push};
      rd_d        = rd_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        wr_q <= wr_d;
        rd_q <= rd_d;
      end
    end

    // Storage is not reset; the pointers alone define emptiness.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= y_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    logic [WIDTH-1:0] w;
    row_word = '0;
    for (int k = 0; k < N; k++) begin
      w = col_head[k];
`ifdef SYSTOLIC_DRAIN_RELU_EN
      if (w[WIDTH-1]) begin
        w = '0;
      end
`endif
      row_word[k*WIDTH +: WIDTH] = w;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    row_d       = row_q;
    overflow_d  = overflow_q | (|col_drop);
    // row_q indexes the next row to load; every loaded row is eventually transferred.
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = row_word;
      out_last_d  = (row_q == LAST_ROW);
      row_d       = (row_q == LAST_ROW) ? '0 : row_q + CW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      row_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      row_q       <= row_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire
